ddr3_cmd_arbiter: RTL and testbench
===================================

// Module: ddr3_cmd_arbiter
// PURPOSE
//   Shares the single DDR3 controller command port between the AXI read path
//   (FETCH requests) and the AXI write path (STORE requests).
//   - Grants one requester at a time and registers its command into a one-deep output stage.
//   - Prefers continuing in the current direction to minimise bus turnarounds.
//   - Caps same-direction streaks so the other direction cannot starve.
//   - Inserts idle turnaround cycles whenever the granted direction changes.
// PARAMETERS
//   ADDRS         32  address width
//   AXI_ID_WIDTH  4   transaction ID width
//   MAX_STREAK    4   max consecutive same-direction grants while other side waits (>=1)
//   TURN_CYCLES   2   idle cycles inserted on READ<->WRITE switch (0 = none)
// PORTS
//   clock         in   1     system clock
//   reset_n       in   1     asynchronous, active-low reset
//   rd_fetch_i    in   1     read path requests a fetch
//   rd_accept_o   out  1     1-cycle pulse: read command captured
//   rd_id_i       in   ID    read transaction ID
//   rd_addr_i     in   ADDRS read address
//   wr_store_i    in   1     write path requests a store
//   wr_accept_o   out  1     1-cycle pulse: write command captured
//   wr_id_i       in   ID    write transaction ID
//   wr_addr_i     in   ADDRS write address
//   ctl_req_o     out  1     command valid to DDR3 controller
//   ctl_accept_i  in   1     controller takes command (ready)
//   ctl_rdwr_o    out  1     1 = READ, 0 = WRITE
//   ctl_id_o      out  ID    command ID
//   ctl_addr_o    out  ADDRS command address
//   busy_o        out  1     high in every state except ST_IDLE
// BEHAVIOUR
//   Reset (async, reset_n=0): all outputs 0; state=ST_IDLE; last_dir=READ; dir_valid=0; streak=0.
//   Requester rule: *_fetch_i/*_store_i and the ID/address must be held stable until the matching *_accept_o pulse.
//   States:
//     ST_IDLE   - Evaluate requests and choose a direction (sel).
//               - Only one requesting: sel = that one.
//               - Both requesting: sel = last_dir if streak < MAX_STREAK, else the opposite direction.
//               - If dir_valid && sel != last_dir && TURN_CYCLES > 0: lock sel, load tcnt = TURN_CYCLES, go ST_TURN.
//               - Otherwise grant now: capture cmd into ctl_* regs, pulse sel's accept, set ctl_req_o=1 next cycle, go ST_ISSUE.
//     ST_TURN   - Decrement tcnt each cycle.
//               - When tcnt reaches 1, grant the locked sel (same capture/pulse), go ST_ISSUE.
//               - Total gap from IDLE decision to ctl_req_o = TURN_CYCLES+1 cycles.
//     ST_ISSUE  - Hold ctl_* stable with ctl_req_o=1.
//               - On ctl_accept_i: drop ctl_req_o, go ST_IDLE.
//               - Update streak: streak = (dir==last_dir && dir_valid) ? sat_inc(streak) : 1.
//               - Then set last_dir=dir, dir_valid=1.
//   Latency: idle port, same direction -> ctl_req_o 1 cycle after request seen; accept pulse in that same decision cycle.
//   Throughput: at most one command per 2 cycles (IDLE then ISSUE); ctl_accept_i held high gives a grant every 2nd cycle.
//   ctl_accept_i while ctl_req_o=0 is ignored.
//   Streak counter saturates at MAX_STREAK.
//   Streak counts only while a grant completes; a lone requester may exceed MAX_STREAK indefinitely.
//   Locked sel in ST_TURN is not re-evaluated, even if the other side requests meanwhile.
//   Reset mid-operation: ctl_req_o drops immediately; the pending command is lost; requesters must re-issue.
//   rd_accept_o and wr_accept_o are never high in the same cycle.
// TESTING
//   1. Lone read, addr=0x100 id=3 -> rd_accept_o pulse cycle N.
//      ctl_req_o=1, rdwr=1, addr=0x100, id=3 from N+1 until accept.
//   2. Controller stalls accept 5 cycles -> ctl_* held constant 5 cycles; no second accept pulse.
//   3. Reads and writes both continuously pending, MAX_STREAK=4, TURN_CYCLES=2 -> grant order R,R,R,R,W,W,W,W,R...
//      Exactly 2 idle cycles precede each switch.
//   4. Write only after a read, TURN_CYCLES=0 -> write granted in the first IDLE cycle with no gap.
//   5. Write asserts during ST_TURN toward READ -> READ still granted; write served next per arbitration.
//   6. reset_n low while ST_ISSUE -> ctl_req_o/busy_o 0 asynchronously.
//      After release, the first grant has no turnaround.

Source files
------------

// File: rtl/ddr3_cmd_arbiter.sv
// ddr3_cmd_arbiter
// Shares the single DDR3 controller command port between the read path
// (fetch requests) and the write path (store requests). One command at a
// time is granted into a one-deep output stage. The arbiter keeps going in
// the current direction to avoid bus turnarounds, but caps a same-direction
// streak while the other side is waiting, and inserts idle cycles whenever
// the granted direction flips.
//
// state    | meaning
// ST_IDLE  | output stage empty; evaluate requests and grant or start a turnaround
// ST_TURN  | direction change in progress; idle until tcnt runs down, then grant sel_lock
// ST_ISSUE | command presented on ctl_*; waiting for ctl_accept_i

module ddr3_cmd_arbiter #(
   parameter int ADDRS        = 32,
   parameter int AXI_ID_WIDTH = 4,
   parameter int MAX_STREAK   = 4,
   parameter int TURN_CYCLES  = 2
) (
   input  logic                    clock,
   input  logic                    reset_n,

   input  logic                    rd_fetch_i,
   output logic                    rd_accept_o,
   input  logic [AXI_ID_WIDTH-1:0] rd_id_i,
   input  logic [ADDRS-1:0]        rd_addr_i,

   input  logic                    wr_store_i,
   output logic                    wr_accept_o,
   input  logic [AXI_ID_WIDTH-1:0] wr_id_i,
   input  logic [ADDRS-1:0]        wr_addr_i,

   output logic                    ctl_req_o,
   input  logic                    ctl_accept_i,
   output logic                    ctl_rdwr_o,
   output logic [AXI_ID_WIDTH-1:0] ctl_id_o,
   output logic [ADDRS-1:0]        ctl_addr_o,

   output logic                    busy_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TURN  = 2'd1,
      ST_ISSUE = 2'd2
   } state_t;

   localparam logic DIR_RD = 1'b1;
   localparam logic DIR_WR = 1'b0;

   // tcnt must hold TURN_CYCLES; streak must hold MAX_STREAK
   localparam int TW = $clog2(TURN_CYCLES + 2);
   localparam int SW = $clog2(MAX_STREAK + 1);

   localparam logic [TW-1:0] TURN_LOAD  = TW'(TURN_CYCLES);
   localparam logic [SW-1:0] STREAK_CAP = SW'(MAX_STREAK);
   localparam logic          HAS_TURN   = (TURN_CYCLES > 0);

   state_t          state;
   state_t          state_nxt;

   logic            last_dir;
   logic            dir_valid;
   logic [SW-1:0]   streak;
   logic [TW-1:0]   tcnt;
   logic            sel_lock;

   logic            sel;
   logic            any_req;
   logic            need_turn;
   logic            grant;
   logic            grant_dir;
   logic            load_turn;
   logic            complete;

   assign any_req = rd_fetch_i | wr_store_i;

   // Direction choice for this cycle's requests: stay on last_dir unless the
   // streak cap is hit while both sides are waiting
   always_comb begin
      sel = DIR_WR;
      if (rd_fetch_i && wr_store_i)
         sel = (streak < STREAK_CAP) ? last_dir : ~last_dir;
      else if (rd_fetch_i)
         sel = DIR_RD;
   end

   // A turnaround is only needed once a direction has actually been used
   assign need_turn = HAS_TURN & dir_valid & (sel != last_dir);

   // Next-state and grant decode
   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      grant_dir = sel;
      load_turn = 1'b0;
      complete  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (any_req) begin
               if (need_turn) begin
                  load_turn = 1'b1;
                  state_nxt = ST_TURN;
               end else begin
                  grant     = 1'b1;
                  grant_dir = sel;
                  state_nxt = ST_ISSUE;
               end
            end
         end
         ST_TURN: begin
            // <= guards against a stuck counter; tcnt is loaded with >= 1
            if (tcnt <= TW'(1)) begin
               grant     = 1'b1;
               grant_dir = sel_lock;
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (ctl_accept_i) begin
               complete  = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Accept pulses are decoded in the decision cycle itself; gating with
   // reset_n keeps them quiet while the block is held in reset
   assign rd_accept_o = reset_n & grant & (grant_dir == DIR_RD);
   assign wr_accept_o = reset_n & grant & (grant_dir == DIR_WR);

   assign ctl_req_o = (state == ST_ISSUE);
   assign busy_o    = (state != ST_IDLE);

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Turnaround down-counter and the direction locked for it
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tcnt     <= '0;
         sel_lock <= DIR_RD;
      end else if (load_turn) begin
         tcnt     <= TURN_LOAD;
         sel_lock <= sel;
      end else if (state == ST_TURN && tcnt != '0) begin
         tcnt <= tcnt - TW'(1);
      end
   end

   // One-deep command output stage, loaded on every grant
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ctl_rdwr_o <= 1'b0;
         ctl_id_o   <= '0;
         ctl_addr_o <= '0;
      end else if (grant) begin
         ctl_rdwr_o <= grant_dir;
         ctl_id_o   <= (grant_dir == DIR_RD) ? rd_id_i   : wr_id_i;
         ctl_addr_o <= (grant_dir == DIR_RD) ? rd_addr_i : wr_addr_i;
      end
   end

   // Direction history: updated only when the controller takes a command
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         last_dir  <= DIR_RD;
         dir_valid <= 1'b0;
         streak    <= '0;
      end else if (complete) begin
         if (dir_valid && ctl_rdwr_o == last_dir)
            streak <= (streak == STREAK_CAP) ? streak : streak + SW'(1);
         else
            streak <= SW'(1);
         last_dir  <= ctl_rdwr_o;
         dir_valid <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ddr3_cmd_arbiter.sv
// Testbench for ddr3_cmd_arbiter: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a queue-based model.

module tb_ddr3_cmd_arbiter;

   localparam int AW      = 32;
   localparam int IW      = 4;
   localparam int TB_MAX  = 4;
   localparam int TB_TURN = 2;
   localparam int NV      = 24;

   logic          clock;
   logic          reset_n;
   logic          rd_fetch, rd_accept, wr_store, wr_accept;
   logic [IW-1:0] rd_id, wr_id, ctl_id;
   logic [AW-1:0] rd_addr, wr_addr, ctl_addr;
   logic          ctl_req, ctl_accept, ctl_rdwr, busy;

   logic          z_rd_fetch, z_rd_accept, z_wr_store, z_wr_accept;
   logic [IW-1:0] z_rd_id, z_wr_id, z_ctl_id;
   logic [AW-1:0] z_rd_addr, z_wr_addr, z_ctl_addr;
   logic          z_ctl_req, z_ctl_accept, z_ctl_rdwr, z_busy;

   int vectors     = 0;
   int miscompares = 0;

   // inputs rd,wr,acc | expected rd_accept,wr_accept | ctl_req,ctl_rdwr,busy
   typedef struct packed {
      logic rd;
      logic wr;
      logic acc;
      logic e_racc;
      logic e_wacc;
      logic e_req;
      logic e_rdwr;
      logic e_busy;
   } vec_t;

   typedef struct packed {
      logic          dir;
      logic [IW-1:0] id;
      logic [AW-1:0] addr;
   } cmd_t;

   vec_t tbl [NV];

   cmd_t m_out [$];
   bit   m_hist [$];
   int   m_wait;
   bit   m_lock;
   bit   r_pend, w_pend;

   ddr3_cmd_arbiter #(.ADDRS(AW), .AXI_ID_WIDTH(IW), .MAX_STREAK(TB_MAX), .TURN_CYCLES(TB_TURN)) dut (
      .clock(clock), .reset_n(reset_n),
      .rd_fetch_i(rd_fetch), .rd_accept_o(rd_accept), .rd_id_i(rd_id), .rd_addr_i(rd_addr),
      .wr_store_i(wr_store), .wr_accept_o(wr_accept), .wr_id_i(wr_id), .wr_addr_i(wr_addr),
      .ctl_req_o(ctl_req), .ctl_accept_i(ctl_accept), .ctl_rdwr_o(ctl_rdwr),
      .ctl_id_o(ctl_id), .ctl_addr_o(ctl_addr), .busy_o(busy)
   );

   ddr3_cmd_arbiter #(.ADDRS(AW), .AXI_ID_WIDTH(IW), .MAX_STREAK(TB_MAX), .TURN_CYCLES(0)) dut0 (
      .clock(clock), .reset_n(reset_n),
      .rd_fetch_i(z_rd_fetch), .rd_accept_o(z_rd_accept), .rd_id_i(z_rd_id), .rd_addr_i(z_rd_addr),
      .wr_store_i(z_wr_store), .wr_accept_o(z_wr_accept), .wr_id_i(z_wr_id), .wr_addr_i(z_wr_addr),
      .ctl_req_o(z_ctl_req), .ctl_accept_i(z_ctl_accept), .ctl_rdwr_o(z_ctl_rdwr),
      .ctl_id_o(z_ctl_id), .ctl_addr_o(z_ctl_addr), .busy_o(z_busy)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check1(input string name, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic checkw(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 with reset released
   task automatic do_reset();
      reset_n    = 1'b0;
      rd_fetch   = 1'b1;
      wr_store   = 1'b1;
      ctl_accept = 1'b1;
      z_rd_fetch = 1'b0;
      z_wr_store = 1'b0;
      z_ctl_accept = 1'b0;
      @(negedge clock);
      check1("rst ctl_req", ctl_req, 1'b0);
      check1("rst busy", busy, 1'b0);
      check1("rst rd_accept", rd_accept, 1'b0);
      check1("rst wr_accept", wr_accept, 1'b0);
      check1("rst ctl_rdwr", ctl_rdwr, 1'b0);
      checkw("rst ctl_id", 32'(ctl_id), 32'd0);
      checkw("rst ctl_addr", ctl_addr, 32'd0);
      rd_fetch   = 1'b0;
      wr_store   = 1'b0;
      ctl_accept = 1'b0;
      @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   // Streak of completed grants in the direction of the most recent one
   function automatic int m_streak();
      int n = 0;
      if (m_hist.size() == 0) return 0;
      for (int i = m_hist.size() - 1; i >= 0; i--) begin
         if (m_hist[i] != m_hist[m_hist.size() - 1] || n >= TB_MAX) break;
         n++;
      end
      return n;
   endfunction

   initial begin
      bit exp_dir [9];
      int gcyc [9];
      bit gdir [9];
      int ng;

      tbl[0]  = 8'b100_10_000;  // lone read: accept in decision cycle
      tbl[1]  = 8'b000_00_111;
      tbl[2]  = 8'b000_00_111;  // controller stalls
      tbl[3]  = 8'b000_00_111;
      tbl[4]  = 8'b000_00_111;
      tbl[5]  = 8'b000_00_111;
      tbl[6]  = 8'b001_00_111;  // taken
      tbl[7]  = 8'b010_00_000;  // write after read: turnaround starts
      tbl[8]  = 8'b010_00_001;
      tbl[9]  = 8'b010_01_001;  // write granted after 2 idle cycles
      tbl[10] = 8'b001_00_101;
      tbl[11] = 8'b100_00_000;  // read after write: turnaround
      tbl[12] = 8'b110_00_001;  // write shows up during turn toward read
      tbl[13] = 8'b110_10_001;  // locked read still granted
      tbl[14] = 8'b011_00_111;
      tbl[15] = 8'b010_00_000;  // write served next, with its own turnaround
      tbl[16] = 8'b010_00_001;
      tbl[17] = 8'b010_01_001;
      tbl[18] = 8'b001_00_101;
      tbl[19] = 8'b001_00_000;  // accept with no request outstanding is ignored
      tbl[20] = 8'b001_00_000;
      tbl[21] = 8'b010_01_000;  // same direction: no gap
      tbl[22] = 8'b001_00_101;
      tbl[23] = 8'b000_00_000;

      exp_dir = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

      reset_n    = 1'b0;
      rd_fetch   = 1'b0;
      wr_store   = 1'b0;
      ctl_accept = 1'b0;
      rd_id      = 4'd3;
      rd_addr    = 32'h0000_0100;
      wr_id      = 4'hA;
      wr_addr    = 32'h2000_0040;
      z_rd_fetch = 1'b0;
      z_wr_store = 1'b0;
      z_ctl_accept = 1'b0;
      z_rd_id    = 4'd5;
      z_rd_addr  = 32'h0000_0800;
      z_wr_id    = 4'd6;
      z_wr_addr  = 32'h0000_0900;
      @(posedge clock);
      #1;

      // Directed vector table
      do_reset();
      for (int i = 0; i < NV; i++) begin
         rd_fetch   = tbl[i].rd;
         wr_store   = tbl[i].wr;
         ctl_accept = tbl[i].acc;
         @(negedge clock);
         check1($sformatf("v%0d rd_accept", i), rd_accept, tbl[i].e_racc);
         check1($sformatf("v%0d wr_accept", i), wr_accept, tbl[i].e_wacc);
         check1($sformatf("v%0d ctl_req", i), ctl_req, tbl[i].e_req);
         check1($sformatf("v%0d busy", i), busy, tbl[i].e_busy);
         if (tbl[i].e_req) begin
            check1($sformatf("v%0d ctl_rdwr", i), ctl_rdwr, tbl[i].e_rdwr);
            checkw($sformatf("v%0d ctl_id", i), 32'(ctl_id), tbl[i].e_rdwr ? 32'd3 : 32'hA);
            checkw($sformatf("v%0d ctl_addr", i), ctl_addr, tbl[i].e_rdwr ? 32'h100 : 32'h2000_0040);
         end
         @(posedge clock);
         #1;
      end

      // Both sides continuously pending, controller always ready
      do_reset();
      rd_fetch   = 1'b1;
      wr_store   = 1'b1;
      ctl_accept = 1'b1;
      ng = 0;
      for (int c = 0; c < 60 && ng < 9; c++) begin
         @(negedge clock);
         check1("streak exclusive accepts", rd_accept & wr_accept, 1'b0);
         if (rd_accept || wr_accept) begin
            gdir[ng] = rd_accept;
            gcyc[ng] = c;
            ng++;
         end
         @(posedge clock);
         #1;
      end
      checkw("streak grant count", ng, 9);
      for (int i = 0; i < ng; i++) begin
         check1($sformatf("streak grant%0d dir", i), gdir[i], exp_dir[i]);
         if (i > 0)
            checkw($sformatf("streak grant%0d spacing", i), gcyc[i] - gcyc[i-1],
                   (exp_dir[i] == exp_dir[i-1]) ? 32'd2 : 32'(TB_TURN + 2));
      end

      // Reset while a command is on the port
      do_reset();
      rd_fetch = 1'b1;
      @(negedge clock);
      check1("midrst rd_accept", rd_accept, 1'b1);
      @(posedge clock);
      #1;
      rd_fetch = 1'b0;
      @(negedge clock);
      check1("midrst ctl_req before", ctl_req, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      check1("midrst ctl_req async", ctl_req, 1'b0);
      check1("midrst busy async", busy, 1'b0);
      checkw("midrst ctl_addr async", ctl_addr, 32'd0);
      @(posedge clock);
      #1;
      reset_n  = 1'b1;
      wr_store = 1'b1;
      @(negedge clock);
      check1("postrst wr_accept no turn", wr_accept, 1'b1);
      check1("postrst busy", busy, 1'b0);
      @(posedge clock);
      #1;
      wr_store   = 1'b0;
      ctl_accept = 1'b1;
      @(negedge clock);
      check1("postrst ctl_req", ctl_req, 1'b1);
      check1("postrst ctl_rdwr", ctl_rdwr, 1'b0);
      @(posedge clock);
      #1;
      ctl_accept = 1'b0;

      // Zero-turnaround instance: write right after read has no gap
      do_reset();
      z_rd_fetch = 1'b1;
      @(negedge clock);
      check1("t0 rd_accept", z_rd_accept, 1'b1);
      @(posedge clock);
      #1;
      z_rd_fetch   = 1'b0;
      z_ctl_accept = 1'b1;
      @(negedge clock);
      check1("t0 read ctl_req", z_ctl_req, 1'b1);
      check1("t0 read ctl_rdwr", z_ctl_rdwr, 1'b1);
      @(posedge clock);
      #1;
      z_ctl_accept = 1'b0;
      z_wr_store   = 1'b1;
      @(negedge clock);
      check1("t0 wr_accept no gap", z_wr_accept, 1'b1);
      check1("t0 busy at write grant", z_busy, 1'b0);
      @(posedge clock);
      #1;
      z_wr_store   = 1'b0;
      z_ctl_accept = 1'b1;
      @(negedge clock);
      check1("t0 write ctl_req", z_ctl_req, 1'b1);
      check1("t0 write ctl_rdwr", z_ctl_rdwr, 1'b0);
      checkw("t0 write ctl_addr", z_ctl_addr, 32'h900);
      @(posedge clock);
      #1;
      z_ctl_accept = 1'b0;

      // Randomized traffic against the reference model
      do_reset();
      m_out.delete();
      m_hist.delete();
      m_wait = 0;
      m_lock = 1'b0;
      r_pend = 1'b0;
      w_pend = 1'b0;
      for (int c = 0; c < 1500; c++) begin
         bit   e_racc, e_wacc, e_req, e_busy, g, gd, last, sel;
         cmd_t e_cmd, nc;
         e_racc = 0; e_wacc = 0; e_req = 0; e_busy = 0; g = 0; gd = 0;
         e_cmd = '0;
         if (!r_pend && $urandom_range(0, 99) < 35) begin
            r_pend  = 1'b1;
            rd_id   = 4'($urandom);
            rd_addr = $urandom;
         end
         if (!w_pend && $urandom_range(0, 99) < 35) begin
            w_pend  = 1'b1;
            wr_id   = 4'($urandom);
            wr_addr = $urandom;
         end
         rd_fetch   = r_pend;
         wr_store   = w_pend;
         ctl_accept = ($urandom_range(0, 99) < 55);
         @(negedge clock);

         if (m_out.size() != 0) begin
            e_req  = 1'b1;
            e_busy = 1'b1;
            e_cmd  = m_out[0];
         end else if (m_wait != 0) begin
            e_busy = 1'b1;
            if (m_wait == 1) begin
               g  = 1'b1;
               gd = m_lock;
            end
            m_wait--;
         end else if (r_pend || w_pend) begin
            last = (m_hist.size() == 0) ? 1'b1 : m_hist[m_hist.size() - 1];
            if (r_pend && w_pend)
               sel = (m_streak() < TB_MAX) ? last : !last;
            else
               sel = r_pend;
            if (m_hist.size() != 0 && sel != last && TB_TURN > 0) begin
               m_wait = TB_TURN;
               m_lock = sel;
            end else begin
               g  = 1'b1;
               gd = sel;
            end
         end
         e_racc = g & gd;
         e_wacc = g & !gd;

         check1($sformatf("rnd%0d rd_accept", c), rd_accept, e_racc);
         check1($sformatf("rnd%0d wr_accept", c), wr_accept, e_wacc);
         check1($sformatf("rnd%0d ctl_req", c), ctl_req, e_req);
         check1($sformatf("rnd%0d busy", c), busy, e_busy);
         if (e_req) begin
            check1($sformatf("rnd%0d ctl_rdwr", c), ctl_rdwr, e_cmd.dir);
            checkw($sformatf("rnd%0d ctl_id", c), 32'(ctl_id), 32'(e_cmd.id));
            checkw($sformatf("rnd%0d ctl_addr", c), ctl_addr, e_cmd.addr);
         end

         if (m_out.size() != 0 && ctl_accept) begin
            m_hist.push_back(m_out[0].dir);
            void'(m_out.pop_front());
         end
         if (g) begin
            nc.dir  = gd;
            nc.id   = gd ? rd_id : wr_id;
            nc.addr = gd ? rd_addr : wr_addr;
            m_out.push_back(nc);
            if (gd) r_pend = 1'b0;
            else    w_pend = 1'b0;
         end
         @(posedge clock);
         #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
